// File: rtl/io_downsize64to32_fta.sv
// io_downsize64to32_fta: splits one 64-bit FTA request into one or two 32-bit
// sub-requests (low word first) and merges the sub-responses into a single
// 64-bit response for the bridge response buffer.
// Optional build macro IO_DOWNSIZE_TIMEOUT_EN adds a wait-state watchdog that
// forces an err response after TIMEOUT silent cycles.

package io_downsize64to32_fta_pkg;
    typedef logic [7:0] fta_tid_t;
    typedef logic [4:0] fta_cmd_t;

    typedef struct packed {
        logic        cyc;
        logic        we;
        fta_cmd_t    cmd;
        logic [2:0]  cti;
        logic [1:0]  bte;
        fta_tid_t    tid;
        logic [7:0]  sel;
        logic [31:0] adr;
        logic [63:0] dat;
    } fta_cmd_request64_t;

    typedef struct packed {
        fta_tid_t    tid;
        logic [3:0]  pri;
        logic        stall;
        logic        next;
        logic        ack;
        logic        err;
        logic        rty;
        logic [31:0] adr;
        logic [63:0] dat;
    } fta_cmd_response64_t;

    typedef struct packed {
        logic        cyc;
        logic        we;
        fta_cmd_t    cmd;
        logic [2:0]  cti;
        logic [1:0]  bte;
        fta_tid_t    tid;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } fta_cmd_request32_t;

    typedef struct packed {
        fta_tid_t    tid;
        logic        ack;
        logic        err;
        logic        rty;
        logic [31:0] dat;
    } fta_cmd_response32_t;
endpackage

module io_downsize64to32_fta
    import io_downsize64to32_fta_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CH_ID   = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  fta_cmd_request64_t  s_req,
    output fta_cmd_response64_t s_resp,
    output fta_cmd_request32_t  m_req,
    input  fta_cmd_response32_t m_resp
);

    typedef enum logic [2:0] {
        IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP
    } state_t;

    state_t      state_q, state_d;

    fta_tid_t    tid_q;
    logic [31:0] adr_q;
    logic        we_q;
    fta_cmd_t    cmd_q;
    logic [2:0]  cti_q;
    logic [1:0]  bte_q;
    logic [7:0]  sel_q;
    logic [63:0] dat_q;
    logic [63:0] rdat_q;
    logic        err_q;
    logic        rty_q;

    logic        resp_hit;
    logic        to_expire;

    // Only a response carrying our own tid moves the wait states forward.
    assign resp_hit = (m_resp.ack | m_resp.err | m_resp.rty) && (m_resp.tid == tid_q);

`ifdef IO_DOWNSIZE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] to_cnt_q;

    // Watchdog counts wait cycles; zero in every other state so it restarts on each wait entry.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            to_cnt_q <= 8'd0;
        else if (state_q == WAIT_LO || state_q == WAIT_HI)
            to_cnt_q <= to_cnt_q + 8'd1;
        else
            to_cnt_q <= 8'd0;
    end

    // Expiry lands the response exactly TIMEOUT cycles after wait entry.
    assign to_expire = (to_cnt_q == TO_LAST);
`else
    assign to_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (s_req.cyc) begin
                    if (s_req.sel == 8'h00)
                        state_d = RESP;
                    else if (s_req.sel[3:0] != 4'h0)
                        state_d = ISSUE_LO;
                    else
                        state_d = ISSUE_HI;
                end
            end
            ISSUE_LO: state_d = WAIT_LO;
            ISSUE_HI: state_d = WAIT_HI;
            WAIT_LO: begin
                if (resp_hit) begin
                    if (m_resp.err || m_resp.rty || sel_q[7:4] == 4'h0)
                        state_d = RESP;
                    else
                        state_d = ISSUE_HI;
                end else if (to_expire) begin
                    state_d = RESP;
                end
            end
            WAIT_HI: begin
                if (resp_hit || to_expire)
                    state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch on accept, read-data and status capture during the waits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tid_q  <= '0;
            adr_q  <= '0;
            we_q   <= 1'b0;
            cmd_q  <= '0;
            cti_q  <= '0;
            bte_q  <= '0;
            sel_q  <= '0;
            dat_q  <= '0;
            rdat_q <= '0;
            err_q  <= 1'b0;
            rty_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (s_req.cyc) begin
                        tid_q  <= s_req.tid;
                        adr_q  <= s_req.adr;
                        we_q   <= s_req.we;
                        cmd_q  <= s_req.cmd;
                        cti_q  <= s_req.cti;
                        bte_q  <= s_req.bte;
                        sel_q  <= s_req.sel;
                        dat_q  <= s_req.dat;
                        rdat_q <= '0;
                        err_q  <= 1'b0;
                        rty_q  <= 1'b0;
                    end
                end
                WAIT_LO, WAIT_HI: begin
                    if (resp_hit) begin
                        if (m_resp.err)
                            err_q <= 1'b1;
                        else if (m_resp.rty)
                            rty_q <= 1'b1;
                        else if (state_q == WAIT_LO)
                            rdat_q[31:0] <= m_resp.dat;
                        else
                            rdat_q[63:32] <= m_resp.dat;
                    end else if (to_expire) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode: sub-request pulse in the issue states, response pulse in RESP.
    always_comb begin
        m_req     = '0;
        m_req.adr = 32'hFFFF_FFFF;
        if (state_q == ISSUE_LO || state_q == ISSUE_HI) begin
            m_req.cyc = 1'b1;
            m_req.we  = we_q;
            m_req.cmd = cmd_q;
            m_req.cti = cti_q;
            m_req.bte = bte_q;
            m_req.tid = tid_q;
            if (state_q == ISSUE_LO) begin
                m_req.adr = {adr_q[31:3], 3'b000};
                m_req.sel = sel_q[3:0];
                m_req.dat = dat_q[31:0];
            end else begin
                m_req.adr = {adr_q[31:3], 3'b100};
                m_req.sel = sel_q[7:4];
                m_req.dat = dat_q[63:32];
            end
        end

        s_resp       = '0;
        s_resp.stall = (state_q != IDLE);
        if (state_q == RESP) begin
            s_resp.ack = ~err_q & ~rty_q;
            s_resp.err = err_q;
            s_resp.rty = rty_q & ~err_q;
            s_resp.dat = rdat_q;
            s_resp.tid = tid_q;
            s_resp.adr = adr_q;
            s_resp.pri = 4'(CH_ID);
        end
    end

endmodule
